// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter_if
// Description : Fetch, data and unified-memory bundle around the arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              imem_en;
    logic [ADDR_W-1:0] imem_addr;
    logic [DATA_W-1:0] imem_rdata;
    logic              imem_wait;
    logic              dmem_r;
    logic              dmem_w;
    logic [ADDR_W-1:0] dmem_addr;
    logic [DATA_W-1:0] dmem_wdata;
    logic [DATA_W-1:0] dmem_rdata;
    logic              dmem_wait;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;

    // Environment view: the CPU ports and the memory together.
    modport master (
        output imem_en, imem_addr, dmem_r, dmem_w, dmem_addr, dmem_wdata,
        output mem_rdata, mem_ready,
        input  imem_rdata, imem_wait, dmem_rdata, dmem_wait,
        input  mem_req, mem_we, mem_addr, mem_wdata
    );

    // Arbiter view.
    modport slave (
        input  imem_en, imem_addr, dmem_r, dmem_w, dmem_addr, dmem_wdata,
        input  mem_rdata, mem_ready,
        output imem_rdata, imem_wait, dmem_rdata, dmem_wait,
        output mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Data-priority arbiter sharing one memory port between fetch
//               and data, with a starvation counter forcing fetch progress.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    mem_port_arbiter_if.slave    bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        IBUSY = 2'd1,
        DBUSY = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_I    = 2'd1,
        OWN_D    = 2'd2
    } owner_t;

    localparam logic [3:0] c_starve_limit = 4'(STARVE_LIMIT);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [3:0] r_starve_cnt;
    logic [3:0] w_starve_nxt;
    owner_t     w_owner;
    logic       w_dreq;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_starve_cnt <= 4'd0;
        end else begin
            r_state      <= w_state_nxt;
            r_starve_cnt <= w_starve_nxt;
        end
    end

    // Busy states lock the owner so the access is never re-arbitrated mid-flight.
    always_comb begin
        w_dreq  = bus.dmem_r | bus.dmem_w;
        w_owner = OWN_NONE;
        if (rst) begin
            case (r_state)
                IBUSY:   w_owner = OWN_I;
                DBUSY:   w_owner = OWN_D;
                default: begin
                    if ((r_starve_cnt >= c_starve_limit) && bus.imem_en)
                        w_owner = OWN_I;
                    else if (w_dreq)
                        w_owner = OWN_D;
                    else if (bus.imem_en)
                        w_owner = OWN_I;
                    else
                        w_owner = OWN_NONE;
                end
            endcase
        end
    end

    always_comb begin
        bus.mem_req    = (w_owner != OWN_NONE);
        bus.mem_we     = (w_owner == OWN_D) && bus.dmem_w;
        bus.mem_addr   = '0;
        bus.mem_wdata  = '0;
        bus.imem_wait  = bus.imem_en & ~((w_owner == OWN_I) & bus.mem_ready);
        bus.dmem_wait  = w_dreq & ~((w_owner == OWN_D) & bus.mem_ready);
        bus.imem_rdata = '0;
        bus.dmem_rdata = '0;
        case (w_owner)
            OWN_I: bus.mem_addr = bus.imem_addr;
            OWN_D: begin
                bus.mem_addr  = bus.dmem_addr;
                bus.mem_wdata = bus.dmem_wdata;
            end
            default: ;
        endcase
        // A withdrawn requester must not see data from the access it abandoned.
        if ((w_owner == OWN_I) && bus.mem_ready && bus.imem_en)
            bus.imem_rdata = bus.mem_rdata;
        if ((w_owner == OWN_D) && bus.mem_ready && w_dreq)
            bus.dmem_rdata = bus.mem_rdata;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if ((w_owner == OWN_I) && !bus.mem_ready)
                    w_state_nxt = IBUSY;
                else if ((w_owner == OWN_D) && !bus.mem_ready)
                    w_state_nxt = DBUSY;
            end
            IBUSY, DBUSY: begin
                if (bus.mem_ready)
                    w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_starve_nxt = r_starve_cnt;
        if (!bus.imem_en)
            w_starve_nxt = 4'd0;
        else if ((w_owner == OWN_I) && bus.mem_ready)
            w_starve_nxt = 4'd0;
        else if ((w_owner != OWN_I) && (r_starve_cnt != 4'hF))
            w_starve_nxt = r_starve_cnt + 4'd1;
    end
endmodule
`default_nettype wire
